// File: rtl/wdg_sched_pkg.sv
// Shared definitions for the watchdog feed scheduler.
// Holds the FSM state encoding, the watchdog key/feed write values and the
// register address codes used on the write port.
package wdg_sched_pkg;

  // Encoding is exported on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    KEY_WR  = 3'd2,
    FEED_WR = 3'd3,
    FAULT   = 3'd4
  } sched_state_e;

  localparam logic [31:0] KEY_VAL  = 32'h5F3C_A99A;
  localparam logic [31:0] FEED_VAL = 32'h0000_0001;

  localparam logic WDG_KEY_ADDR  = 1'b0;
  localparam logic WDG_FEED_ADDR = 1'b1;

endpackage

// File: rtl/wdg_feed_sched_if.sv
// Register write port between the feed scheduler and the watchdog.
//   wr_valid : write request (scheduler -> watchdog)
//   wr_ready : write accepted (watchdog -> scheduler)
//   wr_addr  : 0 = KEY register, 1 = FEED register
//   wr_data  : 32-bit write data
interface wdg_feed_sched_if;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/wdg_sched_win_cnt.sv
// Window counter for the feed scheduler.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force the count to zero (has priority over en_i)
//   en_i         : count up by one this cycle
//   window_i     : window length in cycles; 0 is treated as 1
//   tc_o         : current count is the last cycle of the window
module wdg_sched_win_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] window_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] last_cnt;

  // Terminal count is max(window_i,1) - 1.
  always_comb begin
    last_cnt = '0;
    if (window_i != '0) begin
      last_cnt = window_i - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // window_i is live, so a shrinking window can leave the count past the
  // new terminal value; >= still ends the window instead of waiting for a wrap.
  assign tc_o = (cnt_q >= last_cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wdg_feed_sched.sv
// Task-alive supervisor that decides when the watchdog is fed.
// Collects per-window alive pulses from the requesters and, once every
// enabled requester has checked in, writes KEY then FEED to the watchdog.
// A missed window stops feeding and raises a sticky fault.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : scheduler enable
//   clr_i        : fault clear pulse (only acts in FAULT)
//   mask_i       : requester enable mask
//   window_i     : window length in clk_i cycles
//   alive_i      : per-requester alive pulses
//   wr           : watchdog register write port (master side)
//   fault_o      : sticky missed-window fault
//   missing_o    : requesters absent when the fault was raised
//   feed_cnt_o   : completed feeds, wraps
//   state_o      : current FSM state, for debug
module wdg_feed_sched
  import wdg_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [NUM_REQ-1:0]    mask_i,
  input  logic [CNT_WIDTH-1:0]  window_i,
  input  logic [NUM_REQ-1:0]    alive_i,
  wdg_feed_sched_if.master      wr,
  output logic                  fault_o,
  output logic [NUM_REQ-1:0]    missing_o,
  output logic [FCNT_WIDTH-1:0] feed_cnt_o,
  output logic [2:0]            state_o
);

  sched_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]    alive_q, alive_d;
  logic                  fault_q, fault_d;
  logic [NUM_REQ-1:0]    missing_q, missing_d;
  logic [FCNT_WIDTH-1:0] feed_cnt_q, feed_cnt_d;

  logic [NUM_REQ-1:0] alive_nxt;
  logic               cnt_clr;
  logic               cnt_en;
  logic               win_tc;
  logic               wr_valid;
  logic               wr_addr;
  logic [31:0]        wr_data;

  // The counter only runs in COLLECT; every other state holds it at zero,
  // so each new round starts from cnt = 0 without extra bookkeeping.
  wdg_sched_win_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_win_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .window_i (window_i),
    .tc_o     (win_tc)
  );

  assign alive_nxt = alive_q | (alive_i & mask_i);

  always_comb begin
    state_d    = state_q;
    alive_d    = '0;
    fault_d    = fault_q;
    missing_d  = missing_q;
    feed_cnt_d = feed_cnt_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    wr_valid   = 1'b0;
    wr_addr    = WDG_KEY_ADDR;
    wr_data    = '0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        alive_d = alive_nxt;
        // Completion is checked before expiry so a last-cycle check-in still feeds.
        if (!en_i) begin
          state_d = IDLE;
        end else if ((mask_i != '0) && (alive_nxt == mask_i)) begin
          state_d = KEY_WR;
        end else if (win_tc) begin
          state_d   = FAULT;
          fault_d   = 1'b1;
          missing_d = mask_i & ~alive_nxt;
        end
      end

      // en_i is deliberately ignored here: a key must always be followed by its feed.
      KEY_WR: begin
        wr_valid = 1'b1;
        wr_addr  = WDG_KEY_ADDR;
        wr_data  = KEY_VAL;
        if (wr.wr_ready) begin
          state_d = FEED_WR;
        end
      end

      FEED_WR: begin
        wr_valid = 1'b1;
        wr_addr  = WDG_FEED_ADDR;
        wr_data  = FEED_VAL;
        if (wr.wr_ready) begin
          feed_cnt_d = feed_cnt_q + FCNT_WIDTH'(1);
          state_d    = en_i ? COLLECT : IDLE;
        end
      end

      FAULT: begin
        if (clr_i) begin
          fault_d   = 1'b0;
          missing_d = '0;
          state_d   = COLLECT;
        end else if (!en_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      alive_q    <= '0;
      fault_q    <= 1'b0;
      missing_q  <= '0;
      feed_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      alive_q    <= alive_d;
      fault_q    <= fault_d;
      missing_q  <= missing_d;
      feed_cnt_q <= feed_cnt_d;
    end
  end

  // Write outputs decode only from the state register, so they are held
  // stable for as long as the watchdog stalls.
  assign wr.wr_valid = wr_valid;
  assign wr.wr_addr  = wr_addr;
  assign wr.wr_data  = wr_data;

  assign fault_o    = fault_q;
  assign missing_o  = missing_q;
  assign feed_cnt_o = feed_cnt_q;
  assign state_o    = state_q;

endmodule
